// File: rtl/soc_sysid_reader.sv
// Avalon-MM read master that fetches the system ID and timestamp words
// and compares them against build-time expectations.
module soc_sysid_reader #(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h5A2D_FB50,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state;
    logic [15:0] wait_cnt;

    assign dbg_state = state;

    // Handshake: a read completes in any cycle where avm_read is high and
    // avm_waitrequest is low; while stalled, avm_read/avm_address stay put.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_ID;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        id_value    <= 32'd0;
                        ts_value    <= 32'd0;
                        wait_cnt    <= 16'd0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (!avm_waitrequest) begin
                        wait_cnt <= 16'd0;
                        if (state == RD_ID) begin
                            id_value    <= avm_readdata;
                            avm_address <= 1'b1;
                            state       <= RD_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            id_ok    <= (id_value == EXPECTED_ID);
                            ts_ok    <= (avm_readdata == EXPECTED_TS);
                            avm_read <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end
                    end else if (wait_cnt == TIMEOUT_W) begin
                        // Abort keeps whatever was captured before the stall.
                        timeout  <= 1'b1;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_sysid_reader.sv
// Scoreboard bench for soc_sysid_reader with a configurable stalling slave.
module tb_soc_sysid_reader;

    localparam int W = 75;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          failures = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [W-1:0] exp_q[$];

    int          slv_waits = 0;
    bit          slv_stuck_ts = 1'b0;
    logic [31:0] slv_id_data = 32'h0000_0000;
    logic [31:0] slv_ts_data = 32'h5A2D_FB50;
    int          scnt = 0;
    logic        rst_q = 1'b1;

    soc_sysid_reader #(
        .EXPECTED_ID(32'h0000_0000),
        .EXPECTED_TS(32'h5A2D_FB50),
        .TIMEOUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // ---------------- slave model ----------------
    assign avm_waitrequest = avm_read && ((slv_stuck_ts && avm_address) || (scnt < slv_waits));
    assign avm_readdata    = avm_address ? slv_ts_data : slv_id_data;

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) scnt <= scnt + 1;
        else                             scnt <= 0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int lat, input bit to, input bit iok, input bit tok,
                                        input logic [31:0] id, input logic [31:0] ts);
        return {8'(lat), to, iok, tok, id, ts};
    endfunction

    // ---------------- monitor ----------------
    logic prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0;

    always @(negedge clock) begin
        logic [W-1:0] exp_v;
        if (prev_read && prev_wait && !rst_q && !done)
            check("stall_hold", {73'd0, avm_read, avm_address}, {73'd0, 1'b1, prev_addr});
        if (done) begin
            n_done++;
            check("abort_read_low", {73'd0, avm_read, busy}, '0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                exp_v = exp_q.pop_front();
                check("result", {8'(cyc - start_cyc), timeout, id_ok, ts_ok, id_value, ts_value}, exp_v);
            end
        end
        prev_read = avm_read;
        prev_wait = avm_waitrequest;
        prev_addr = avm_address;
    end

    // ---------------- driver tasks ----------------
    task automatic run_check(input logic [W-1:0] exp_v, input bit chk_clear);
        @(negedge clock);
        start     = 1'b1;
        start_cyc = cyc;
        exp_q.push_back(exp_v);
        @(negedge clock);
        start = 1'b0;
        if (chk_clear)
            check("cleared_on_start", {timeout, id_ok, ts_ok, id_value, ts_value, busy},
                  {3'b000, 64'd0, 1'b1});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200; i++) begin
            if (n_done >= target && exp_q.size() == 0) break;
            @(negedge clock);
        end
        checks++;
        if (n_done < target || exp_q.size() != 0) begin
            failures++;
            $display("FAIL done_wait: got %0d dones expected %0d", n_done, target);
        end
        repeat (2) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_state", {busy, done, id_ok, ts_ok, timeout, id_value, ts_value, avm_read, avm_address},
              '0);

        // Zero-wait good check
        run_check(mk(3, 0, 1, 1, 32'h0, 32'h5A2D_FB50), 1'b1);
        wait_done(1);

        // Bad timestamp
        slv_ts_data = 32'h1234_5678;
        run_check(mk(3, 0, 1, 0, 32'h0, 32'h1234_5678), 1'b0);
        wait_done(2);

        // Four wait states on each read
        slv_ts_data = 32'h5A2D_FB50;
        slv_waits   = 4;
        run_check(mk(11, 0, 1, 1, 32'h0, 32'h5A2D_FB50), 1'b0);
        wait_done(3);

        // Timestamp read stalls forever -> abort after 8 wait cycles
        slv_waits    = 0;
        slv_stuck_ts = 1'b1;
        run_check(mk(11, 1, 0, 0, 32'h0, 32'h0), 1'b0);
        wait_done(4);
        check("read_low_after_abort", {74'd0, avm_read}, '0);
        slv_stuck_ts = 1'b0;

        // Reset in the middle of an ID stall
        slv_waits = 20;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_transfer", {busy, done, id_ok, ts_ok, timeout, id_value, ts_value, avm_read, avm_address},
              '0);
        reset     = 1'b0;
        slv_waits = 0;
        repeat (3) @(negedge clock);
        check("no_done_after_reset", 75'(n_done), 75'd4);

        // Clean check after reset, with a non-zero ID to exercise id_ok=0
        slv_id_data = 32'hDEAD_BEEF;
        run_check(mk(3, 0, 0, 1, 32'hDEAD_BEEF, 32'h5A2D_FB50), 1'b1);
        wait_done(5);
        slv_id_data = 32'h0;

        // Extra start while busy is ignored
        slv_waits = 2;
        run_check(mk(7, 0, 1, 1, 32'h0, 32'h5A2D_FB50), 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(6);
        repeat (6) @(negedge clock);
        check("single_done", 75'(n_done), 75'd6);

        // New start in IDLE clears flags then re-evaluates
        slv_waits   = 0;
        slv_ts_data = 32'h0BAD_0BAD;
        run_check(mk(3, 0, 1, 0, 32'h0, 32'h0BAD_0BAD), 1'b1);
        wait_done(7);

        repeat (4) @(negedge clock);
        check("queue_empty", 75'(exp_q.size()), 75'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/soc_sysid_reader.md
# soc_sysid_reader

Avalon-MM read master that interrogates the system ID peripheral over its control slave and checks the returned values against build-time expectations. On a `start` pulse it reads the ID word (address 0), then the timestamp word (address 1), then reports captured values and pass/fail flags. It sits beside the processor on the SOC interconnect and gives boot or self-test logic a hardware check that the loaded image matches the generated system.

## Interface

Parameters:
- `EXPECTED_ID`, 32'h0000_0000, value required at address 0.
- `EXPECTED_TS`, 32'h5A2D_FB50, value required at address 1.
- `TIMEOUT`, 255, wait-state cycles allowed per read before abort (1..65535).

Ports:
- `clock` in 1: single system clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a check; sampled only in IDLE.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the check completes or aborts.
- `id_ok` out 1: captured ID equals `EXPECTED_ID`.
- `ts_ok` out 1: captured timestamp equals `EXPECTED_TS`.
- `timeout` out 1: last check aborted on wait-state limit.
- `id_value` out 32: captured address-0 word.
- `ts_value` out 32: captured address-1 word.
- `avm_address` out 1: word address to the sysid control slave.
- `avm_read` out 1: read request.
- `avm_readdata` in 32: read data, valid in the cycle `avm_read` is high and `avm_waitrequest` is low.
- `avm_waitrequest` in 1: slave/interconnect stall.

## Operation

- States: IDLE, RD_ID, RD_TS, FINISH.
- IDLE: `avm_read`=0, `busy`=0. `start`=1 -> RD_ID; clears `id_ok`, `ts_ok`, `timeout`, `id_value`, `ts_value`, wait counter.
- RD_ID: `avm_read`=1, `avm_address`=0. Transfer completes when `avm_waitrequest`=0: `avm_readdata` -> `id_value`, counter cleared, -> RD_TS.
- RD_TS: `avm_read`=1, `avm_address`=1. On completion `avm_readdata` -> `ts_value`, -> FINISH.
- FINISH: `avm_read`=0; `done`=1 for exactly one cycle; `id_ok`/`ts_ok` registered from 32-bit equality of captured values; -> IDLE.
- Address and read held stable while `avm_waitrequest`=1 (Avalon rule); no request dropped mid-stall except on timeout.
- Wait counter: 16-bit, increments each cycle in RD_ID/RD_TS with `avm_waitrequest`=1; when it equals `TIMEOUT` in a stalled cycle: `avm_read` drops next cycle, `timeout`=1, `id_ok`=`ts_ok`=0, -> FINISH. Values captured before abort are kept.
- Flags and captured values hold from FINISH until next accepted `start` or `reset`.
- `start` while `busy` or in FINISH: ignored, not queued.
- `start` held high continuously: new check begins on each IDLE visit.

## Timing

- Reset: all outputs 0, state IDLE, counter 0. Reset mid-transfer drops `avm_read` on the next edge; no completion or `done` issued.
- Zero wait states: `start` high at edge N -> `avm_read`=1, addr 0 after N; addr 1 after N+1; `done`=1 and flags valid after N+2; `busy` high for 2 cycles.
- Each wait-state cycle adds one cycle to total latency.
- Timeout: with `avm_waitrequest` stuck high, `done` asserts `TIMEOUT`+1 cycles after the read began.
- Outputs fully registered; no combinational path from `avm_*` inputs to outputs.

## Test plan

- Slave returns 0 at addr 0, 0x5A2DFB50 at addr 1, no waits; `start` one cycle -> `done` 3 cycles later, `id_ok`=1, `ts_ok`=1, `timeout`=0, `ts_value`=0x5A2DFB50.
- Same but addr 1 returns 0x12345678 -> `id_ok`=1, `ts_ok`=0, `ts_value`=0x12345678.
- 4 wait cycles on each read -> `done` 11 cycles after `start`, address/read stable throughout each stall, both flags 1.
- `TIMEOUT`=8, `avm_waitrequest` stuck high in RD_TS -> `timeout`=1, both ok flags 0, `id_value` kept, `avm_read` low after abort.
- `reset` asserted during RD_ID stall -> next cycle all outputs 0, no `done`; subsequent `start` runs a clean check.
- `start` pulsed again while `busy` -> exactly one `done`; `start` in IDLE after that -> flags cleared then re-evaluated.
